// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline for the five-stage MIPS datapath: carries EX/M/WB
// strobes through ID/EX, EX/MEM and MEM/WB and resolves load-use stalls and taken-branch flushes.
module ctrl_pipe #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       id_ex,
  input  logic [2:0]       id_m,
  input  logic [1:0]       id_wb,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             mem_zero,
  output logic             ex_reg_dst,
  output logic             ex_alu_src,
  output logic [1:0]       ex_alu_op,
  output logic [REG_W-1:0] ex_dst,
  output logic             mem_branch,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_reg_write,
  output logic             wb_mem_to_reg,
  output logic [REG_W-1:0] wb_dst,
  output logic             hazard_stall,
  output logic             pc_src
);

  typedef struct packed {
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
  } ex_t;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
  } m_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_t;

  typedef struct packed {
    ex_t              ex;
    m_t               m;
    wb_t              wb;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
  } idex_t;

  typedef struct packed {
    m_t               m;
    wb_t              wb;
    logic [REG_W-1:0] dst;
  } exmem_t;

  typedef struct packed {
    wb_t              wb;
    logic [REG_W-1:0] dst;
  } memwb_t;

  idex_t  idex_q;
  exmem_t exmem_q;
  memwb_t memwb_q;

  // A taken branch outranks the load-use stall: the load being waited on is squashed anyway.
  assign pc_src       = exmem_q.m.branch & mem_zero;
  assign hazard_stall = ~pc_src & id_valid & idex_q.m.mem_read &
                        ((idex_q.rt == id_rs) | (idex_q.rt == id_rt));

  assign ex_reg_dst    = idex_q.ex.reg_dst;
  assign ex_alu_op     = idex_q.ex.alu_op;
  assign ex_alu_src    = idex_q.ex.alu_src;
  assign ex_dst        = idex_q.ex.reg_dst ? idex_q.rd : idex_q.rt;

  assign mem_branch    = exmem_q.m.branch;
  assign mem_read      = exmem_q.m.mem_read;
  assign mem_write     = exmem_q.m.mem_write;

  assign wb_reg_write  = memwb_q.wb.reg_write;
  assign wb_mem_to_reg = memwb_q.wb.mem_to_reg;
  assign wb_dst        = memwb_q.dst;

  // NOTE: reset is synchronous (tested inside the clocked block), and all
  // state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      memwb_q <= '{wb: exmem_q.wb, dst: exmem_q.dst};
      if (pc_src) begin
        idex_q  <= '0;
        exmem_q <= '0;
      end else begin
        exmem_q <= '{m: idex_q.m, wb: idex_q.wb, dst: ex_dst};
        if (hazard_stall || !id_valid) begin
          idex_q <= '0;
        end else begin
          idex_q <= '{ex: id_ex, m: id_m, wb: id_wb, rt: id_rt, rd: id_rd};
        end
      end
    end
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed hazard scenarios followed by random
// traffic, all compared against an instruction-slot model of the pipeline.
module tb_ctrl_pipe;

  localparam int REG_W = 5;

  localparam bit [8:0] NOP   = 9'b0000_000_00;
  localparam bit [8:0] RTYPE = 9'b1100_000_10;
  localparam bit [8:0] LW    = 9'b0001_010_11;
  localparam bit [8:0] SW    = 9'b0001_001_00;
  localparam bit [8:0] BEQ   = 9'b0010_100_00;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       id_ex;
  logic [2:0]       id_m;
  logic [1:0]       id_wb;
  logic             id_valid;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic             mem_zero;
  logic             ex_reg_dst, ex_alu_src;
  logic [1:0]       ex_alu_op;
  logic [REG_W-1:0] ex_dst;
  logic             mem_branch, mem_read, mem_write;
  logic             wb_reg_write, wb_mem_to_reg;
  logic [REG_W-1:0] wb_dst;
  logic             hazard_stall, pc_src;

  ctrl_pipe #(.REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_ex(id_ex), .id_m(id_m), .id_wb(id_wb), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .mem_zero(mem_zero),
    .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .ex_dst(ex_dst), .mem_branch(mem_branch), .mem_read(mem_read),
    .mem_write(mem_write), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst),
    .hazard_stall(hazard_stall), .pc_src(pc_src)
  );

  always #5 clk = ~clk;

  // One instruction slot per stage: 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    bit [8:0]       bundle;
    bit [REG_W-1:0] rt, rd, dst;
  } slot_t;

  slot_t pipe [3];
  slot_t empty_slot;
  int    n_cmp = 0;
  int    n_mis = 0;
  int    obs_stall, obs_pc, obs_wbw;

  function automatic bit m_pc();
    return pipe[1].bundle[4] & mem_zero;
  endfunction

  function automatic bit m_stall();
    return !m_pc() && id_valid && pipe[0].bundle[3] &&
           (pipe[0].rt == id_rs || pipe[0].rt == id_rt);
  endfunction

  function automatic bit [REG_W-1:0] m_ex_dst();
    return pipe[0].bundle[8] ? pipe[0].rd : pipe[0].rt;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("pc_src",        8'(pc_src),        8'(m_pc()));
    check("hazard_stall",  8'(hazard_stall),  8'(m_stall()));
    check("ex_reg_dst",    8'(ex_reg_dst),    8'(pipe[0].bundle[8]));
    check("ex_alu_op",     8'(ex_alu_op),     8'(pipe[0].bundle[7:6]));
    check("ex_alu_src",    8'(ex_alu_src),    8'(pipe[0].bundle[5]));
    check("ex_dst",        8'(ex_dst),        8'(m_ex_dst()));
    check("mem_branch",    8'(mem_branch),    8'(pipe[1].bundle[4]));
    check("mem_read",      8'(mem_read),      8'(pipe[1].bundle[3]));
    check("mem_write",     8'(mem_write),     8'(pipe[1].bundle[2]));
    check("wb_reg_write",  8'(wb_reg_write),  8'(pipe[2].bundle[1]));
    check("wb_mem_to_reg", 8'(wb_mem_to_reg), 8'(pipe[2].bundle[0]));
    check("wb_dst",        8'(wb_dst),        8'(pipe[2].dst));
  endtask

  // Advance the model by one clock using the inputs held across the edge.
  task automatic model_edge();
    bit    pc, st;
    slot_t s;
    pc = m_pc();
    st = m_stall();
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) pipe[i] = empty_slot;
    end else begin
      pipe[2] = pipe[1];
      if (pc) begin
        pipe[1] = empty_slot;
        pipe[0] = empty_slot;
      end else begin
        s        = pipe[0];
        s.dst    = m_ex_dst();
        pipe[1]  = s;
        if (st || !id_valid) begin
          pipe[0] = empty_slot;
        end else begin
          pipe[0].bundle = {id_ex, id_m, id_wb};
          pipe[0].rt     = id_rt;
          pipe[0].rd     = id_rd;
          pipe[0].dst    = '0;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    obs_stall += int'(hazard_stall);
    obs_pc    += int'(pc_src);
    obs_wbw   += int'(wb_reg_write);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input bit [8:0] b, input int rs, input int rt, input int rd,
                       input bit mz);
    id_valid = v;
    {id_ex, id_m, id_wb} = b;
    id_rs    = REG_W'(rs);
    id_rt    = REG_W'(rt);
    id_rd    = REG_W'(rd);
    mem_zero = mz;
  endtask

  task automatic clear_obs();
    obs_stall = 0;
    obs_pc    = 0;
    obs_wbw   = 0;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, NOP, 0, 0, 0, 1'b0);
      cycle();
    end
  endtask

  task automatic branch_seq(input bit taken);
    clear_obs();
    drive(1'b1, BEQ,   1, 2, 0, 1'b0);     cycle();
    drive(1'b1, RTYPE, 1, 2, 11, 1'b0);    cycle();
    drive(1'b1, RTYPE, 1, 2, 12, taken);   cycle();
    nops(5);
  endtask

  initial begin
    bit [8:0] b;
    rst_n = 1'b0;
    drive(1'b1, RTYPE, 0, 3, 7, 1'b0);

    // Reset held two cycles with a live RTYPE in decode; it enters EX after release.
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    nops(4);

    // Load-use: LW rt=4 then a dependent RTYPE held through the stall.
    clear_obs();
    drive(1'b1, LW,    0, 4, 0, 1'b0);     cycle();
    drive(1'b1, RTYPE, 4, 5, 6, 1'b0);     cycle();
    cycle();
    nops(4);
    check("loaduse_stall_cycles", 8'(obs_stall), 8'd1);
    check("loaduse_writes",       8'(obs_wbw),   8'd2);

    // Taken branch squashes both younger RTYPEs; not taken lets both write back.
    branch_seq(1'b1);
    check("taken_pc_cycles", 8'(obs_pc),  8'd1);
    check("taken_writes",    8'(obs_wbw), 8'd0);
    branch_seq(1'b0);
    check("nottaken_pc_cycles", 8'(obs_pc),  8'd0);
    check("nottaken_writes",    8'(obs_wbw), 8'd2);

    // Branch resolves while a load-use condition exists in decode.
    clear_obs();
    drive(1'b1, BEQ,   0, 0, 0, 1'b0);     cycle();
    drive(1'b1, LW,    0, 8, 0, 1'b0);     cycle();
    drive(1'b1, RTYPE, 8, 9, 10, 1'b1);    cycle();
    nops(4);
    check("prio_stall_cycles", 8'(obs_stall), 8'd0);
    check("prio_pc_cycles",    8'(obs_pc),    8'd1);

    // Reset while an LW sits in EX/MEM: nothing may write back afterwards.
    drive(1'b1, LW, 0, 2, 0, 1'b0);        cycle();
    drive(1'b1, SW, 0, 1, 0, 1'b0);        cycle();
    rst_n = 1'b0;
    drive(1'b0, NOP, 0, 0, 0, 1'b0);       cycle();
    rst_n = 1'b1;
    clear_obs();
    nops(4);
    check("reset_midflight_writes", 8'(obs_wbw), 8'd0);

    // Random traffic, narrow register range so hazards occur often.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(5))
        0:       b = RTYPE;
        1:       b = LW;
        2:       b = SW;
        3:       b = BEQ;
        4:       b = NOP;
        default: b = 9'($urandom);
      endcase
      rst_n = ($urandom_range(49) != 0);
      drive($urandom_range(99) < 85, b, int'($urandom_range(3)), int'($urandom_range(3)),
            int'($urandom_range(31)), 1'($urandom));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
